// File: rtl/mem_dp.sv
// Dual-port word memory: port A read/write, port B read-only, both with 1-cycle registered reads.
// A sweep writes CLEAR_VALUE to every word after reset or on clear_req; accesses are dropped while busy.
module mem_dp #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      ADDR_BITS   = 8,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 a_enable,
    input  logic                 a_write,
    input  logic [ADDR_BITS-1:0] a_address,
    input  logic [WIDTH-1:0]     a_in_bus,
    output logic [WIDTH-1:0]     a_out_bus,
    output logic                 a_valid,
    input  logic                 b_enable,
    input  logic [ADDR_BITS-1:0] b_address,
    output logic [WIDTH-1:0]     b_out_bus,
    output logic                 b_valid,
    input  logic                 clear_req,
    output logic                 busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic                   a_acc, b_acc, a_wr, fwd_ab;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;

    logic [WIDTH-1:0]       a_out_q, a_out_d, b_out_q, b_out_d;
    logic                   a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    assign busy      = (state_q == ST_CLEAR);
    assign a_acc     = a_enable && !busy;
    assign b_acc     = b_enable && !busy;
    assign a_wr      = a_acc && a_write;
    assign fwd_ab    = a_wr && (a_address == b_address);

    assign a_out_bus = a_out_q;
    assign b_out_bus = b_out_q;
    assign a_valid   = a_valid_q;
    assign b_valid   = b_valid_q;

    // Sweep sequencing and selection of the single memory write port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = a_address;
        mem_wdata = a_in_bus;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = CLEAR_VALUE;
                if (cnt_q == ADDR_BITS'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end
            ST_READY: begin
                mem_we = a_wr;
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Read data: write-first on A, and B forwards A's same-address write.
    always_comb begin
        a_valid_d = a_acc;
        b_valid_d = b_acc;
        a_out_d   = a_out_q;
        b_out_d   = b_out_q;
        if (a_acc) begin
            a_out_d = a_write ? a_in_bus : mem_q[a_address];
        end
        if (b_acc) begin
            b_out_d = fwd_ab ? a_in_bus : mem_q[b_address];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            a_out_q   <= '0;
            b_out_q   <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Storage is never reset; only the sweep defines its contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_dp.sv
// Scoreboard bench for mem_dp (WIDTH=8, ADDR_BITS=4, CLEAR_VALUE=8'hA5).
// A reference model pushes expected read data when a request is driven; outputs are popped and compared after the edge.
module tb_mem_dp;

    logic       clock;
    logic       reset_n;
    logic       a_enable, a_write, b_enable, clear_req;
    logic [3:0] a_address, b_address;
    logic [7:0] a_in_bus;
    logic [7:0] a_out_bus, b_out_bus;
    logic       a_valid, b_valid, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [16];
    logic       busy_m;
    int         cnt_m;
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] last_a, last_b;

    mem_dp #(
        .WIDTH      (8),
        .ADDR_BITS  (4),
        .CLEAR_VALUE(8'hA5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_enable  (a_enable),
        .a_write   (a_write),
        .a_address (a_address),
        .a_in_bus  (a_in_bus),
        .a_out_bus (a_out_bus),
        .a_valid   (a_valid),
        .b_enable  (b_enable),
        .b_address (b_address),
        .b_out_bus (b_out_bus),
        .b_valid   (b_valid),
        .clear_req (clear_req),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        a_enable  = 1'b0;
        a_write   = 1'b0;
        b_enable  = 1'b0;
        clear_req = 1'b0;
    endtask

    // Model one clock edge, then compare DUT outputs against the scoreboard.
    task automatic step();
        logic [7:0] e;
        if (!busy_m) begin
            if (a_enable) qa.push_back(a_write ? a_in_bus : mem_m[a_address]);
            if (b_enable) qb.push_back((a_enable && a_write && a_address == b_address) ? a_in_bus : mem_m[b_address]);
            if (a_enable && a_write) mem_m[a_address] = a_in_bus;
            if (clear_req) begin
                busy_m = 1'b1;
                cnt_m  = 0;
            end
        end else begin
            mem_m[cnt_m] = 8'hA5;
            if (cnt_m == 15) busy_m = 1'b0;
            else cnt_m++;
        end
        @(posedge clock);
        #1;
        check_val("busy", 64'(busy), 64'(busy_m));
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check_val("a_valid", 64'(a_valid), 64'd1);
            check_val("a_data", 64'(a_out_bus), 64'(e));
            last_a = e;
        end else begin
            check_val("a_valid_idle", 64'(a_valid), 64'd0);
            check_val("a_hold", 64'(a_out_bus), 64'(last_a));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check_val("b_valid", 64'(b_valid), 64'd1);
            check_val("b_data", 64'(b_out_bus), 64'(e));
            last_b = e;
        end else begin
            check_val("b_valid_idle", 64'(b_valid), 64'd0);
            check_val("b_hold", 64'(b_out_bus), 64'(last_b));
        end
    endtask

    task automatic model_reset();
        busy_m = 1'b1;
        cnt_m  = 0;
        qa.delete();
        qb.delete();
        last_a = 8'h00;
        last_b = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_a_valid"}, 64'(a_valid), 64'd0);
        check_val({tag, "_b_valid"}, 64'(b_valid), 64'd0);
        check_val({tag, "_a_out"}, 64'(a_out_bus), 64'd0);
        check_val({tag, "_b_out"}, 64'(b_out_bus), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    // Count steps until busy drops; optional clear_req pulse on step pulse_at.
    task automatic count_sweep(input string tag, input int pulse_at);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            clear_req = (n == pulse_at);
            step();
            n++;
        end
        clear_req = 1'b0;
        check_val(tag, 64'(n), 64'd16);
    endtask

    task automatic b_read(input logic [3:0] addr);
        idle();
        b_enable  = 1'b1;
        b_address = addr;
        step();
    endtask

    task automatic a_wr(input logic [3:0] addr, input logic [7:0] data);
        idle();
        a_enable  = 1'b1;
        a_write   = 1'b1;
        a_address = addr;
        a_in_bus  = data;
        step();
    endtask

    initial begin
        idle();
        a_address = '0;
        b_address = '0;
        a_in_bus  = '0;
        reset_n   = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Sweep after reset with B held requesting: all dropped.
        b_enable  = 1'b1;
        b_address = 4'd3;
        count_sweep("sweep_after_reset", -1);
        for (int i = 0; i < 16; i++) begin
            b_read(4'(i));
            check_val("cleared_word", 64'(b_out_bus), 64'hA5);
        end

        // Write-first on A with same-address B read.
        idle();
        a_enable  = 1'b1;
        a_write   = 1'b1;
        a_address = 4'd5;
        a_in_bus  = 8'h3C;
        b_enable  = 1'b1;
        b_address = 4'd5;
        step();
        check_val("wf_a", 64'(a_out_bus), 64'h3C);
        check_val("wf_b", 64'(b_out_bus), 64'h3C);
        idle();
        step();

        // Same-address reads on both ports.
        a_enable  = 1'b1;
        a_address = 4'd5;
        b_enable  = 1'b1;
        b_address = 4'd5;
        step();
        idle();

        // Back-to-back A reads.
        for (int i = 0; i < 4; i++) a_wr(4'(i), 8'(i));
        idle();
        for (int i = 0; i < 4; i++) begin
            a_enable  = 1'b1;
            a_address = 4'(i);
            step();
            check_val("b2b_data", 64'(a_out_bus), 64'(i));
        end
        idle();
        step();

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            a_enable  = 1'($urandom_range(0, 1));
            a_write   = 1'($urandom_range(0, 1));
            a_address = 4'($urandom_range(0, 15));
            a_in_bus  = 8'($urandom_range(0, 255));
            b_enable  = 1'($urandom_range(0, 1));
            b_address = ($urandom_range(0, 3) == 0) ? a_address : 4'($urandom_range(0, 15));
            step();
        end

        // Clear request with a same-cycle B read that is still accepted.
        a_wr(4'd15, 8'h11);
        idle();
        clear_req = 1'b1;
        b_enable  = 1'b1;
        b_address = 4'd15;
        step();
        check_val("clr_b_data", 64'(b_out_bus), 64'h11);
        check_val("clr_b_valid", 64'(b_valid), 64'd1);
        idle();
        count_sweep("sweep_after_clear", -1);
        b_read(4'd15);
        check_val("post_clear_word", 64'(b_out_bus), 64'hA5);

        // clear_req during the sweep must not lengthen it.
        a_wr(4'd2, 8'h77);
        idle();
        clear_req = 1'b1;
        step();
        idle();
        count_sweep("sweep_ignore_clear", 4);

        // Reset in the middle of a sweep, buses holding non-zero data.
        a_wr(4'd9, 8'h5A);
        idle();
        clear_req = 1'b1;
        step();
        idle();
        for (int i = 0; i < 7; i++) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        check_reset_outputs("midrst_hold");
        reset_n = 1'b1;
        count_sweep("sweep_after_midrst", -1);
        b_read(4'd9);
        check_val("midrst_word", 64'(b_out_bus), 64'hA5);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_dp.md
MEM_DP -- requirements
Module: mem_dp

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set data word width in bits (1..64).
REQ-002 Parameter ADDR_BITS, default 8, SHALL set address width; DEPTH = 2**ADDR_BITS words.
REQ-003 Parameter CLEAR_VALUE, default 0, SHALL set the WIDTH-bit word written during clear sweeps.
REQ-004 Ports SHALL be: clock  in  1  sole clock, all state on posedge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 a_enable  in  1  port A access request (read, or write if a_write).
REQ-007 a_write  in  1  port A write qualifier, honoured only with a_enable.
REQ-008 a_address  in  ADDR_BITS  port A word address.
REQ-009 a_in_bus  in  WIDTH  port A write data.
REQ-010 a_out_bus  out  WIDTH  port A registered read data.
REQ-011 a_valid  out  1  a_out_bus holds data from an accepted request.
REQ-012 b_enable  in  1  port B read request (port B is read-only).
REQ-013 b_address  in  ADDR_BITS  port B word address.
REQ-014 b_out_bus  out  WIDTH  port B registered read data.
REQ-015 b_valid  out  1  b_out_bus holds data from an accepted request.
REQ-016 clear_req  in  1  single-cycle request to re-run the clear sweep.
REQ-017 busy  out  1  high while the clear sweep runs; requests not accepted.

Function
REQ-018 FSM SHALL have two states, CLEAR and READY, plus an ADDR_BITS-wide sweep counter.
REQ-019 In CLEAR the block SHALL write CLEAR_VALUE to word[counter] each cycle, increment counter, and move to READY in the cycle after writing word DEPTH-1 (sweep = DEPTH cycles).
REQ-020 Counter SHALL not wrap to re-sweep; reaching DEPTH-1 ends the sweep.
REQ-021 In READY, clear_req=1 SHALL enter CLEAR with counter=0 on the next edge; any a/b request that same cycle is still accepted.
REQ-022 clear_req during CLEAR SHALL be ignored (sweep not restarted).
REQ-023 busy SHALL equal (state==CLEAR) combinationally from the state register.
REQ-024 A request SHALL be accepted only when its enable=1 and busy=0; requests during busy are dropped, not queued.
REQ-025 Read latency SHALL be exactly 1 cycle: accepted at edge N, data and valid=1 visible after edge N, for one cycle.
REQ-026 valid SHALL be 0 in every cycle following an edge without an accepted request on that port; out_bus SHALL hold its last value when valid=0.
REQ-027 Accepted port A write SHALL update word[a_address] at that edge and also return a_in_bus on a_out_bus with a_valid=1 (write-first).
REQ-028 Port B read of the address port A writes in the same cycle SHALL return the new data (write-first forwarding).
REQ-029 Port A read and port B read of the same address in the same cycle SHALL both return the stored word.
REQ-030 Memory contents SHALL NOT be initialised from file; contents are defined only after the first sweep completes.

Reset
REQ-031 reset_n low SHALL immediately force state=CLEAR, counter=0, a_valid=0, b_valid=0, a_out_bus=0, b_out_bus=0, busy=1.
REQ-032 After reset_n rises the sweep SHALL start on the first posedge; reset asserted mid-sweep or mid-access SHALL restart from counter=0, dropping any in-flight read.
REQ-033 Memory array SHALL NOT be reset directly; only the sweep clears it.

Verification (WIDTH=8, ADDR_BITS=4, CLEAR_VALUE=8'hA5)
REQ-034 Release reset, hold b_enable=1 -> busy=1 for exactly 16 cycles, b_valid=0 throughout; then read all 16 addresses -> each 8'hA5.
REQ-035 After sweep, A writes 8'h3C to addr 5 while B reads addr 5 same cycle -> next cycle a_out_bus=b_out_bus=8'h3C, both valid=1; following idle cycle both valid=0, buses hold 8'h3C.
REQ-036 Write 8'h11 to addr 15, pulse clear_req with a B read of addr 15 same cycle -> b_out_bus=8'h11 valid=1, then busy=1 for 16 cycles; read addr 15 after -> 8'hA5.
REQ-037 During sweep at counter=7 assert reset_n=0 for one cycle -> outputs zeroed immediately, busy stays 1, sweep takes full 16 cycles after release.
REQ-038 Back-to-back A reads of addresses 0..3 with pre-written 8'h00..8'h03 -> a_valid high 4 consecutive cycles, data 8'h00,8'h01,8'h02,8'h03 in order.
REQ-039 Pulse clear_req during busy -> sweep length unchanged at 16 cycles.
